mem_arbiter: RTL and testbench

Shares the core's single 256-bit RAM line port between the instruction cache and the data cache. Each cache holds a line request until the arbiter returns a one-cycle `done`. The arbiter grants one requester at a time, drives the RAM for a fixed access latency, captures read data, and returns it. It sits between the caches and the top-level `ram_*` pins of `core`.

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arbiter_arb_rr2.sv | 22 ++
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the cache-to-RAM line arbiter.
// Holds the default widths, the line-offset width used to align RAM addresses,
// and the state, grant and operation encodings.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned LINE_WIDTH = 256;
  // A 256-bit line spans 32 bytes, so the low 5 address bits select a byte within it.
  localparam int unsigned LINE_OFF_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_ICACHE = 1'b0,
    GNT_DCACHE = 1'b1
  } grant_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } line_op_t;

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-way round-robin pick (combinational).
// Ports:
//   req0, req1 : pending requests (req0 is the icache side, GNT_ICACHE)
//   last       : requester granted most recently
//   valid_c    : at least one request is pending
//   pick1_c    : grant goes to req1 (otherwise to req0 when valid_c)
module mem_arbiter_arb_rr2
  import mem_arbiter_pkg::*;
(
  input  logic   req0,
  input  logic   req1,
  input  grant_t last,
  output logic   valid_c,
  output logic   pick1_c
);

  assign valid_c = req0 | req1;

  // req1 wins when it is alone, or on a conflict when req0 was served last.
  assign pick1_c = req1 & (~req0 | (last == GNT_ICACHE));

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single RAM line port between the instruction and data caches.
// One requester is granted at a time; the RAM command is held for MEM_LATENCY
// cycles, read data is captured on the last of those cycles, and the granted
// port receives a one-cycle done pulse in the following cycle.
// Ports:
//   CLK, RST                        : clock, asynchronous active-low reset
//   i_read_op, i_addr               : icache line read request
//   i_rdata, i_done                 : icache returned line and completion pulse
//   d_read_op, d_write_op, d_addr,
//   d_wdata                         : dcache line request (read+write counts as write)
//   d_rdata, d_done                 : dcache returned line and completion pulse
//   ram_read_op, ram_write_op,
//   ram_addr, ram_data_o            : RAM command, line-aligned address, write data
//   ram_data_i                      : RAM read data
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_WIDTH,
  parameter int unsigned LINE_W      = LINE_WIDTH,
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_read_op,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_read_op,
  input  logic              d_write_op,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_done,
  output logic              ram_read_op,
  output logic              ram_write_op,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [LINE_W-1:0] ram_data_o,
  input  logic [LINE_W-1:0] ram_data_i
);

  localparam int unsigned       CNT_W    = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  arb_state_t        state_q, state_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  grant_t            last_q, last_nxt;
  grant_t            gnt_q, gnt_nxt;
  line_op_t          op_q, op_nxt;

  logic [LINE_W-1:0] i_rdata_nxt, d_rdata_nxt, ram_data_o_nxt;
  logic [ADDR_W-1:0] ram_addr_nxt;
  logic              i_done_nxt, d_done_nxt, ram_read_op_nxt, ram_write_op_nxt;

  logic              d_req;
  logic              any_req_c, pick_d_c;

  assign d_req = d_read_op | d_write_op;

  mem_arbiter_arb_rr2 u_arb (
    .req0    (i_read_op),
    .req1    (d_req),
    .last    (last_q),
    .valid_c (any_req_c),
    .pick1_c (pick_d_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_nxt        = state_q;
    cnt_nxt          = cnt_q;
    last_nxt         = last_q;
    gnt_nxt          = gnt_q;
    op_nxt           = op_q;
    ram_addr_nxt     = ram_addr;
    ram_data_o_nxt   = ram_data_o;
    i_rdata_nxt      = i_rdata;
    d_rdata_nxt      = d_rdata;
    ram_read_op_nxt  = 1'b0;
    ram_write_op_nxt = 1'b0;
    i_done_nxt       = 1'b0;
    d_done_nxt       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (any_req_c) begin
          state_nxt = ST_ACCESS;
          cnt_nxt   = '0;
          gnt_nxt   = pick_d_c ? GNT_DCACHE : GNT_ICACHE;
          last_nxt  = gnt_nxt;
          // An illegal read+write from the dcache is served as a write.
          op_nxt    = (pick_d_c && d_write_op) ? OP_WRITE : OP_READ;
          ram_addr_nxt                   = pick_d_c ? d_addr : i_addr;
          ram_addr_nxt[LINE_OFF_W-1:0]   = '0;
          ram_data_o_nxt   = pick_d_c ? d_wdata : '0;
          ram_read_op_nxt  = (op_nxt == OP_READ);
          ram_write_op_nxt = (op_nxt == OP_WRITE);
        end
      end

      ST_ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          // Last command cycle: the RAM data is valid now.
          state_nxt = ST_RESP;
          if (op_q == OP_READ) begin
            if (gnt_q == GNT_DCACHE) d_rdata_nxt = ram_data_i;
            else                     i_rdata_nxt = ram_data_i;
          end
          i_done_nxt = (gnt_q == GNT_ICACHE);
          d_done_nxt = (gnt_q == GNT_DCACHE);
        end else begin
          cnt_nxt          = cnt_q + CNT_W'(1);
          ram_read_op_nxt  = (op_q == OP_READ);
          ram_write_op_nxt = (op_q == OP_WRITE);
        end
      end

      ST_RESP: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_q       <= GNT_ICACHE;
      gnt_q        <= GNT_ICACHE;
      op_q         <= OP_READ;
      ram_addr     <= '0;
      ram_data_o   <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      ram_read_op  <= 1'b0;
      ram_write_op <= 1'b0;
      i_done       <= 1'b0;
      d_done       <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      cnt_q        <= cnt_nxt;
      last_q       <= last_nxt;
      gnt_q        <= gnt_nxt;
      op_q         <= op_nxt;
      ram_addr     <= ram_addr_nxt;
      ram_data_o   <= ram_data_o_nxt;
      i_rdata      <= i_rdata_nxt;
      d_rdata      <= d_rdata_nxt;
      ram_read_op  <= ram_read_op_nxt;
      ram_write_op <= ram_write_op_nxt;
      i_done       <= i_done_nxt;
      d_done       <= d_done_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 uses MEM_LATENCY=4, instance 1 uses MEM_LATENCY=1.
// A transaction-level model (grant cycle plus latency arithmetic) is checked against
// both instances every cycle, alongside hand-computed directed expectations.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          i_read_op    [2];
  logic [AW-1:0] i_addr       [2];
  logic [LW-1:0] i_rdata      [2];
  logic          i_done       [2];
  logic          d_read_op    [2];
  logic          d_write_op   [2];
  logic [AW-1:0] d_addr       [2];
  logic [LW-1:0] d_wdata      [2];
  logic [LW-1:0] d_rdata      [2];
  logic          d_done       [2];
  logic          ram_read_op  [2];
  logic          ram_write_op [2];
  logic [AW-1:0] ram_addr     [2];
  logic [LW-1:0] ram_data_o   [2];
  logic [LW-1:0] ram_data_i   [2];

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .MEM_LATENCY(4)) u_dut4 (
    .CLK(clk), .RST(rst_n),
    .i_read_op(i_read_op[0]), .i_addr(i_addr[0]), .i_rdata(i_rdata[0]), .i_done(i_done[0]),
    .d_read_op(d_read_op[0]), .d_write_op(d_write_op[0]), .d_addr(d_addr[0]),
    .d_wdata(d_wdata[0]), .d_rdata(d_rdata[0]), .d_done(d_done[0]),
    .ram_read_op(ram_read_op[0]), .ram_write_op(ram_write_op[0]), .ram_addr(ram_addr[0]),
    .ram_data_o(ram_data_o[0]), .ram_data_i(ram_data_i[0])
  );

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .MEM_LATENCY(1)) u_dut1 (
    .CLK(clk), .RST(rst_n),
    .i_read_op(i_read_op[1]), .i_addr(i_addr[1]), .i_rdata(i_rdata[1]), .i_done(i_done[1]),
    .d_read_op(d_read_op[1]), .d_write_op(d_write_op[1]), .d_addr(d_addr[1]),
    .d_wdata(d_wdata[1]), .d_rdata(d_rdata[1]), .d_done(d_done[1]),
    .ram_read_op(ram_read_op[1]), .ram_write_op(ram_write_op[1]), .ram_addr(ram_addr[1]),
    .ram_data_o(ram_data_o[1]), .ram_data_i(ram_data_i[1])
  );

  int n_tests;
  int n_fail;
  int cyc;
  int n;

  // Model state: grant cycle (-1 when idle) and the latched transaction.
  int            m_g      [2];
  logic          m_wr     [2];
  logic          m_d      [2];
  logic          m_last_d [2];
  logic [AW-1:0] m_addr   [2];
  logic [LW-1:0] m_wdata  [2];
  logic [LW-1:0] m_ird    [2];
  logic [LW-1:0] m_drd    [2];
  logic          seen_id  [2];
  logic          seen_dd  [2];

  function automatic int lat(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string nm, input int k, input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cyc=%0d got=%h want=%h", nm, k, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input int k, input logic act, input logic exp);
    chk(nm, k, LW'(act), LW'(exp));
  endtask

  // Per-cycle model step: compare this cycle's outputs, then advance.
  task automatic model_cycle(input int k);
    int   L;
    bit   acc, resp, pd;
    L = lat(k);
    if (!rst_n) begin
      m_g[k] = -1; m_last_d[k] = 1'b0; m_ird[k] = '0; m_drd[k] = '0;
      chk1("rst_ram_read_op",  k, ram_read_op[k],  1'b0);
      chk1("rst_ram_write_op", k, ram_write_op[k], 1'b0);
      chk1("rst_i_done",       k, i_done[k],       1'b0);
      chk1("rst_d_done",       k, d_done[k],       1'b0);
      chk("rst_ram_addr",      k, LW'(ram_addr[k]), '0);
      chk("rst_i_rdata",       k, i_rdata[k], '0);
      chk("rst_d_rdata",       k, d_rdata[k], '0);
      return;
    end
    if (m_g[k] >= 0 && cyc >= m_g[k] + L + 2) m_g[k] = -1;
    acc  = (m_g[k] >= 0) && (cyc > m_g[k]) && (cyc <= m_g[k] + L);
    resp = (m_g[k] >= 0) && (cyc == m_g[k] + L + 1);
    chk1("ram_read_op",  k, ram_read_op[k],  acc && !m_wr[k]);
    chk1("ram_write_op", k, ram_write_op[k], acc && m_wr[k]);
    chk1("i_done",       k, i_done[k],       resp && !m_d[k]);
    chk1("d_done",       k, d_done[k],       resp && m_d[k]);
    if (acc) chk("ram_addr", k, LW'(ram_addr[k]), LW'(m_addr[k]));
    if (acc && m_wr[k]) chk("ram_data_o", k, ram_data_o[k], m_wdata[k]);
    chk("i_rdata", k, i_rdata[k], m_ird[k]);
    chk("d_rdata", k, d_rdata[k], m_drd[k]);
    if (acc && cyc == m_g[k] + L && !m_wr[k]) begin
      if (m_d[k]) m_drd[k] = ram_data_i[k];
      else        m_ird[k] = ram_data_i[k];
    end
    if (m_g[k] < 0 && (i_read_op[k] || d_read_op[k] || d_write_op[k])) begin
      pd = (d_read_op[k] || d_write_op[k]) && (!i_read_op[k] || !m_last_d[k]);
      m_g[k]      = cyc;
      m_d[k]      = pd;
      m_last_d[k] = pd;
      m_wr[k]     = pd && d_write_op[k];
      m_addr[k]   = (pd ? d_addr[k] : i_addr[k]) & ~32'h1F;
      m_wdata[k]  = d_wdata[k];
    end
  endtask

  // One clock cycle: check at negedge, advance, then requesters drop served requests.
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      seen_id[k] = i_done[k];
      seen_dd[k] = d_done[k];
      model_cycle(k);
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (seen_id[k]) i_read_op[k] = 1'b0;
      if (seen_dd[k]) begin d_read_op[k] = 1'b0; d_write_op[k] = 1'b0; end
    end
  endtask

  // Step until the selected done is high (bounded); n = cycles stepped.
  task automatic wait_done(input int k, input bit is_d, output int cnt);
    cnt = 0;
    while (cnt < 30 && !(is_d ? d_done[k] : i_done[k])) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_read_op[k] = 1'b0; i_addr[k] = '0; d_read_op[k] = 1'b0; d_write_op[k] = 1'b0;
      d_addr[k] = '0; d_wdata[k] = '0; ram_data_i[k] = '0;
      m_g[k] = -1; m_wr[k] = 1'b0; m_d[k] = 1'b0; m_last_d[k] = 1'b0;
      m_addr[k] = '0; m_wdata[k] = '0; m_ird[k] = '0; m_drd[k] = '0;
      seen_id[k] = 1'b0; seen_dd[k] = 1'b0;
    end
    step(); step();
    chk1("reset_read_op", 0, ram_read_op[0], 1'b0);
    chk("reset_i_rdata", 0, i_rdata[0], '0);
    rst_n = 1'b1;
    step();

    // Isolated icache read
    ram_data_i[0] = {32{8'hA5}}; i_addr[0] = 32'h0000_1234; i_read_op[0] = 1'b1;
    step();
    chk1("t1_read_op", 0, ram_read_op[0], 1'b1);
    chk("t1_addr", 0, LW'(ram_addr[0]), LW'(32'h0000_1220));
    wait_done(0, 1'b0, n);
    chk("t1_latency", 0, LW'(n + 1), LW'(5));
    chk("t1_rdata", 0, i_rdata[0], {32{8'hA5}});
    step();

    // Isolated dcache write
    ram_data_i[0] = {32{8'h5A}}; d_wdata[0] = {16{16'h1122}}; d_addr[0] = 32'h40;
    d_write_op[0] = 1'b1;
    step();
    chk1("t2_write_op", 0, ram_write_op[0], 1'b1);
    chk("t2_wdata", 0, ram_data_o[0], {16{16'h1122}});
    chk("t2_addr", 0, LW'(ram_addr[0]), LW'(32'h40));
    wait_done(0, 1'b1, n);
    chk("t2_latency", 0, LW'(n + 1), LW'(5));
    chk("t2_d_rdata", 0, d_rdata[0], '0);
    step();

    // Reset pulse clears captured data and last_grant
    rst_n = 1'b0; #1;
    chk("t2r_i_rdata", 0, i_rdata[0], '0);
    step();
    rst_n = 1'b1;
    step();

    // Simultaneous requests from reset: dcache first, icache right after
    ram_data_i[0] = {8{32'hCAFE_0001}};
    i_addr[0] = 32'h100; d_addr[0] = 32'h200; i_read_op[0] = 1'b1; d_read_op[0] = 1'b1;
    step();
    chk("t3_first_addr", 0, LW'(ram_addr[0]), LW'(32'h200));
    wait_done(0, 1'b1, n);
    chk("t3_d_latency", 0, LW'(n + 1), LW'(5));
    chk("t3_d_rdata", 0, d_rdata[0], {8{32'hCAFE_0001}});
    wait_done(0, 1'b0, n);
    chk("t3_i_after_d", 0, LW'(n), LW'(6));
    step();

    // dcache served alone, then a conflict goes to the icache
    ram_data_i[0] = {8{32'hBEEF_0002}}; d_addr[0] = 32'h500; d_read_op[0] = 1'b1;
    wait_done(0, 1'b1, n);
    chk("t4_d_alone", 0, LW'(n), LW'(5));
    step();
    i_addr[0] = 32'h600; d_addr[0] = 32'h700; i_read_op[0] = 1'b1; d_read_op[0] = 1'b1;
    step();
    chk("t4_first_addr", 0, LW'(ram_addr[0]), LW'(32'h600));
    wait_done(0, 1'b0, n);
    chk("t4_i_latency", 0, LW'(n + 1), LW'(5));
    wait_done(0, 1'b1, n);
    chk("t4_d_after_i", 0, LW'(n), LW'(6));
    step();

    // dcache request arrives during an icache access
    ram_data_i[0] = {8{32'h1357_9BDF}}; i_addr[0] = 32'h800; i_read_op[0] = 1'b1;
    step(); step();
    d_addr[0] = 32'h3FF; d_wdata[0] = {8{32'h7777_0003}}; d_write_op[0] = 1'b1;
    step();
    chk("t5_addr_stable", 0, LW'(ram_addr[0]), LW'(32'h800));
    chk1("t5_no_write", 0, ram_write_op[0], 1'b0);
    wait_done(0, 1'b0, n);
    chk("t5_i_rest", 0, LW'(n), LW'(2));
    wait_done(0, 1'b1, n);
    chk("t5_d_after_i", 0, LW'(n), LW'(6));
    step();

    // Reset during ACCESS cycle 2 with both requests held
    ram_data_i[0] = {8{32'h0F0F_AAAA}};
    i_addr[0] = 32'h900; d_addr[0] = 32'hA00; i_read_op[0] = 1'b1; d_read_op[0] = 1'b1;
    step();
    chk("t6_first_addr", 0, LW'(ram_addr[0]), LW'(32'h900));
    step();
    rst_n = 1'b0; #1;
    chk1("t6_rd_drop", 0, ram_read_op[0], 1'b0);
    chk1("t6_wr_drop", 0, ram_write_op[0], 1'b0);
    step(); step();
    rst_n = 1'b1;
    wait_done(0, 1'b1, n);
    chk("t6_d_latency", 0, LW'(n), LW'(5));
    chk("t6_d_rdata", 0, d_rdata[0], {8{32'h0F0F_AAAA}});
    wait_done(0, 1'b0, n);
    chk("t6_i_after_d", 0, LW'(n), LW'(6));
    step();

    // MEM_LATENCY=1 instance
    ram_data_i[1] = {32{8'h3C}}; i_addr[1] = 32'h1234; i_read_op[1] = 1'b1;
    wait_done(1, 1'b0, n);
    chk("t7_i_latency", 1, LW'(n), LW'(2));
    chk("t7_i_rdata", 1, i_rdata[1], {32{8'h3C}});
    step();
    d_addr[1] = 32'h40; d_wdata[1] = {8{32'hDEAD_BEEF}};
    d_read_op[1] = 1'b1; d_write_op[1] = 1'b1;
    step();
    chk1("t7_rw_is_write", 1, ram_write_op[1], 1'b1);
    chk1("t7_rw_no_read", 1, ram_read_op[1], 1'b0);
    chk("t7_wdata", 1, ram_data_o[1], {8{32'hDEAD_BEEF}});
    wait_done(1, 1'b1, n);
    chk("t7_d_latency", 1, LW'(n + 1), LW'(2));
    chk("t7_d_rdata_kept", 1, d_rdata[1], '0);
    step();
    ram_data_i[1] = {32{8'hC3}}; i_addr[1] = 32'h80; d_addr[1] = 32'hC0;
    i_read_op[1] = 1'b1; d_read_op[1] = 1'b1;
    wait_done(1, 1'b0, n);
    chk("t7_conflict_i", 1, LW'(n), LW'(2));
    wait_done(1, 1'b1, n);
    chk("t7_conflict_d", 1, LW'(n), LW'(3));
    chk("t7_d_rdata", 1, d_rdata[1], {32{8'hC3}});
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
